// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load request sequencing, byte-lane extraction and sign/zero extension
module load_align_unit #(
  parameter int REG_LEN = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [2:0]         load_type,
  input  logic [REG_LEN-1:0] addr,
  output logic               busy,
  output logic               mem_req,
  output logic [REG_LEN-1:0] mem_addr,
  output logic [3:0]         mem_be,
  input  logic               mem_rvalid,
  input  logic [REG_LEN-1:0] mem_rdata,
  output logic [REG_LEN-1:0] rd_data,
  output logic               rd_valid,
  output logic               misalign_err,
  output logic               bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         ltype;
  logic [1:0]         loff;
  logic [7:0]         wait_cnt;
  logic               legal;
  logic               timeout_hit;
  logic [3:0]         be_calc;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [REG_LEN-1:0] ext;

  // Classify the incoming request and build its byte-enable mask
  always_comb begin
    legal   = 1'b0;
    be_calc = 4'b1111;
    case (load_type)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    case (load_type[1:0])
      2'b00:   be_calc = 4'b0001 << addr[1:0];
      2'b01:   be_calc = 4'b0011 << addr[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  // Pick the addressed lane from the returned word and extend it to full width
  always_comb begin
    byte_sel = mem_rdata[{loff, 3'b000} +: 8];
    half_sel = mem_rdata[{loff[1], 4'b0000} +: 16];
    case (ltype)
      3'b000:  ext = {{(REG_LEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  ext = {{(REG_LEN-8){1'b0}}, byte_sel};
      3'b001:  ext = {{(REG_LEN-16){half_sel[15]}}, half_sel};
      3'b101:  ext = {{(REG_LEN-16){1'b0}}, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a response in the timeout cycle still completes the load
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid && legal) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid)       state_nxt = S_RESP;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    busy     = (state != S_IDLE);
    mem_req  = (state == S_REQ);
    rd_valid = (state == S_RESP);
  end

  // Request latches, wait counter, result register and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ltype        <= 3'b000;
      loff         <= 2'b00;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      rd_data      <= '0;
      wait_cnt     <= 8'd0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= (state == S_IDLE) && req_valid && !legal;
      bus_err      <= (state == S_WAIT) && !mem_rvalid && timeout_hit;
      if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                 wait_cnt <= 8'd0;
      if (state == S_IDLE && req_valid) begin
        ltype <= load_type;
        loff  <= addr[1:0];
        if (legal) begin
          mem_addr <= {addr[REG_LEN-1:2], 2'b00};
          mem_be   <= be_calc;
        end
      end
      if (state == S_WAIT && mem_rvalid) rd_data <= ext;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed bench with timestamp-based reference model for load_align_unit
module tb_load_align_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic [2:0]  load_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        misalign_err;
  logic        bus_err;

  int tests = 0;
  int fails = 0;
  int mreq_cnt = 0;

  load_align_unit #(.REG_LEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .load_type(load_type), .addr(addr),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rd_data(rd_data),
    .rd_valid(rd_valid), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] t, input logic [31:0] a);
    int off = int'(a % 4);
    case (t)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (off % 2) == 0;
      3'd2:       return off == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
    int off = int'(a % 4);
    int m;
    case (t)
      3'd0, 3'd4: m = 1 << off;
      3'd1, 3'd5: m = 3 << off;
      default:    m = 15;
    endcase
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    longint v;
    case (t)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * off)) & 32'hFF);
        if (t == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF);
        if (t == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return 32'(v);
  endfunction

  // Reference model: tracks the accept cycle and completion cycle of the current load
  int          cyc = 0;
  int          acc = -1;
  int          done = -1;
  int          bad = -10;
  bit          got = 1'b0;
  logic [2:0]  m_type = 3'b000;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] e_rd = 32'h0;
  logic [31:0] e_maddr = 32'h0;
  logic [3:0]  e_be = 4'h0;

  always @(negedge clk) begin
    bit e_busy, e_req, e_rv, e_berr, e_mis;
    if (rst) begin
      acc = -1; done = -1; bad = -10; got = 1'b0;
      e_rd = 32'h0; e_maddr = 32'h0; e_be = 4'h0;
      chk("reset busy", {31'h0, busy}, 32'h0);
      chk("reset outputs", {mem_req, rd_valid, misalign_err, bus_err}, 32'h0);
      chk("reset rd_data", rd_data, 32'h0);
      chk("reset mem_addr/be", mem_addr | {28'h0, mem_be}, 32'h0);
    end else begin
      e_busy = (acc >= 0) && (cyc >= acc + 1) && (done < 0 || cyc <= done || (got && cyc == done + 1));
      e_req  = (acc >= 0) && (cyc == acc + 1);
      e_rv   = (acc >= 0) && (done >= 0) && got && (cyc == done + 1);
      e_berr = (acc >= 0) && (done >= 0) && !got && (cyc == done + 1);
      e_mis  = (cyc == bad + 1);
      chk("model busy", {31'h0, busy}, {31'h0, e_busy});
      chk("model mem_req", {31'h0, mem_req}, {31'h0, e_req});
      chk("model rd_valid", {31'h0, rd_valid}, {31'h0, e_rv});
      chk("model bus_err", {31'h0, bus_err}, {31'h0, e_berr});
      chk("model misalign_err", {31'h0, misalign_err}, {31'h0, e_mis});
      chk("model rd_data", rd_data, e_rd);
      chk("model mem_addr", mem_addr, e_maddr);
      chk("model mem_be", {28'h0, mem_be}, {28'h0, e_be});
      if (!e_busy && req_valid) begin
        if (model_legal(load_type, addr)) begin
          acc = cyc; done = -1; got = 1'b0;
          m_type = load_type; m_addr = addr;
          e_maddr = {addr[31:2], 2'b00};
          e_be = model_be(load_type, addr);
        end else begin
          bad = cyc;
        end
      end else if (acc >= 0 && done < 0 && cyc >= acc + 2) begin
        if (mem_rvalid) begin
          done = cyc; got = 1'b1;
          e_rd = model_load(m_type, m_addr, mem_rdata);
        end else if (cyc - (acc + 2) == TIMEOUT - 1) begin
          done = cyc; got = 1'b0;
        end
      end
    end
    cyc++;
  end

  // Count read strobes so a test can confirm exactly one per access
  always @(negedge clk) if (mem_req === 1'b1) mreq_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [2:0] t, input logic [31:0] a);
    load_type = t; addr = a; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input int delay, input logic [31:0] d);
    repeat (delay) tick();
    mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #20000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int req_before;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("lit reset busy", {31'h0, busy}, 32'h0);
    chk("lit reset rd_data", rd_data, 32'h0);
    rst = 1'b0;
    tick();

    // LB at offset 3, response one cycle after mem_req
    do_req(3'b000, 32'h103);
    chk("lit lb mem_req", {31'h0, mem_req}, 32'h1);
    chk("lit lb mem_addr", mem_addr, 32'h100);
    chk("lit lb mem_be", {28'h0, mem_be}, 32'h8);
    respond(1, 32'h80FF_1234);
    chk("lit lb rd_valid", {31'h0, rd_valid}, 32'h1);
    chk("lit lb rd_data", rd_data, 32'hFFFF_FF80);
    tick();

    // LHU and LH from the upper half
    do_req(3'b101, 32'h22);
    chk("lit lhu mem_be", {28'h0, mem_be}, 32'hC);
    respond(1, 32'h9ABC_5678);
    chk("lit lhu rd_data", rd_data, 32'h0000_9ABC);
    tick();
    do_req(3'b001, 32'h22);
    respond(3, 32'h9ABC_5678);
    chk("lit lh rd_valid", {31'h0, rd_valid}, 32'h1);
    chk("lit lh rd_data", rd_data, 32'hFFFF_9ABC);
    tick();

    // Misaligned LW and illegal funct3
    do_req(3'b010, 32'h41);
    chk("lit lw misalign_err", {31'h0, misalign_err}, 32'h1);
    chk("lit lw misalign no mem_req", {31'h0, mem_req}, 32'h0);
    chk("lit lw misalign busy", {31'h0, busy}, 32'h0);
    tick();
    chk("lit misalign one cycle", {31'h0, misalign_err}, 32'h0);
    do_req(3'b011, 32'h40);
    chk("lit illegal type misalign_err", {31'h0, misalign_err}, 32'h1);
    tick();

    // Timeout with no response, then a response exactly at the timeout cycle
    do_req(3'b010, 32'h40);
    repeat (16) tick();
    chk("lit timeout busy before", {31'h0, busy}, 32'h1);
    chk("lit timeout no early bus_err", {31'h0, bus_err}, 32'h0);
    tick();
    chk("lit timeout bus_err", {31'h0, bus_err}, 32'h1);
    chk("lit timeout busy after", {31'h0, busy}, 32'h0);
    tick();
    do_req(3'b010, 32'h44);
    respond(16, 32'h1234_5678);
    chk("lit late rd_valid", {31'h0, rd_valid}, 32'h1);
    chk("lit late no bus_err", {31'h0, bus_err}, 32'h0);
    chk("lit late rd_data", rd_data, 32'h1234_5678);
    tick();

    // Second request while waiting, then a stray response in IDLE
    req_before = mreq_cnt;
    do_req(3'b010, 32'h80);
    tick();
    load_type = 3'b000; addr = 32'h85; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    respond(0, 32'hCAFE_F00D);
    chk("lit busy-req rd_data", rd_data, 32'hCAFE_F00D);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("lit stray rvalid rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("lit single mem_req", 32'(mreq_cnt - req_before), 32'h1);
    tick();

    // Reset during WAIT, late response afterwards, then a normal load
    do_req(3'b010, 32'h10);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("lit async reset busy", {31'h0, busy}, 32'h0);
    chk("lit async reset rd_data", rd_data, 32'h0);
    chk("lit async reset mem_be", {28'h0, mem_be}, 32'h0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("lit post-reset rd_valid", {31'h0, rd_valid}, 32'h0);
    tick();
    chk("lit post-reset rd_valid 2", {31'h0, rd_valid}, 32'h0);
    do_req(3'b100, 32'h11);
    chk("lit lbu mem_be", {28'h0, mem_be}, 32'h2);
    chk("lit lbu mem_addr", mem_addr, 32'h10);
    respond(1, 32'h0000_C300);
    chk("lit lbu rd_valid", {31'h0, rd_valid}, 32'h1);
    chk("lit lbu rd_data", rd_data, 32'h0000_00C3);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Read-direction counterpart of the store-side byte-lane logic.
- Accepts a load request from the core and issues a word-aligned read to data memory with the byte-enable mask.
- Waits for the memory response, then extracts the addressed byte, halfword or word and sign- or zero-extends it.
- Returns the registered result to the register-file write-back path and holds the core stalled while the access is outstanding.

Parameters:
- REG_LEN, 32, data and address width in bits.
- TIMEOUT, 16, maximum cycles spent in WAIT before a bus error; legal range 2..255.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  load request strobe from the core.
- load_type  in  3  RISC-V funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; all other codes are illegal.
- addr  in  REG_LEN  byte address of the load.
- busy  out  1  stall to the core; high whenever state is not IDLE.
- mem_req  out  1  one-cycle read strobe to data memory.
- mem_addr  out  REG_LEN  word-aligned address, {addr[REG_LEN-1:2], 2'b00}.
- mem_be  out  4  byte enables of the read.
- mem_rvalid  in  1  read-data-valid strobe from memory.
- mem_rdata  in  REG_LEN  read word from memory.
- rd_data  out  REG_LEN  aligned and extended load result.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- misalign_err  out  1  one-cycle strobe; the request was misaligned or used an illegal load_type.
- bus_err  out  1  one-cycle strobe; the memory response timed out.

Behaviour:
- Reset: state=IDLE; all outputs 0, including rd_data; the timeout counter is cleared.
  - Reset asserted mid-access abandons the access. No rd_valid is produced, and a late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On req_valid, latch load_type, addr[1:0] and the word address.
  - Illegal request (illegal load_type, LH/LHU with addr[0]=1, or LW with addr[1:0]≠00): pulse misalign_err for 1 cycle (the cycle after acceptance), stay in IDLE, issue no memory access.
  - Legal request: go to REQ.
- REQ:
  - mem_req=1 for exactly this cycle; mem_addr and mem_be are valid this cycle.
  - mem_be = 0001<<addr[1:0] for byte loads, 0011<<addr[1:0] for halfword loads, 1111 for LW.
  - Next state is WAIT. mem_rvalid in this cycle is ignored.
- WAIT:
  - The counter increments every cycle.
  - On mem_rvalid, capture the extracted result into rd_data and go to RESP.
  - If the counter reaches TIMEOUT-1 with no mem_rvalid: pulse bus_err next cycle, leave rd_data unchanged, go to IDLE.
  - If mem_rvalid arrives in the same cycle as the timeout, mem_rvalid wins.
- RESP: rd_valid=1 for this single cycle, then go to IDLE.
- Extraction (b = addr[1:0]):
  - Byte = mem_rdata[8b+7:8b].
  - Half = mem_rdata[31:16] if b[1], else mem_rdata[15:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- busy is high in REQ, WAIT and RESP. req_valid while busy is ignored; the core must hold the request until busy falls.
- mem_rvalid in IDLE or RESP is ignored.
- Latency: accept at cycle N, mem_req at N+1, earliest mem_rvalid at N+2, rd_valid at N+3.
- mem_addr and mem_be hold their last value outside REQ. mem_req, rd_valid, misalign_err and bus_err are 0 except during their defined pulse cycles.

Test Plan:
- LB, addr=0x103, rvalid 1 cycle after mem_req with rdata=0x80FF_1234 → mem_addr=0x100, mem_be=1000, rd_data=0xFFFF_FF80, rd_valid pulses at N+3.
- LHU, addr=0x22, rdata=0x9ABC_5678 → mem_be=1100, rd_data=0x0000_9ABC. LH with the same data → rd_data=0xFFFF_9ABC.
- LW, addr=0x41 → misalign_err for 1 cycle, no mem_req, busy stays 0. load_type=011 → misalign_err.
- LW, addr=0x40, memory never responds, TIMEOUT=16 → bus_err pulse, return to IDLE, busy low. Repeat with rvalid exactly at the timeout cycle → rd_valid and no bus_err.
- Second req_valid during WAIT → ignored; exactly one mem_req, and stray mem_rvalid in IDLE produces no rd_valid.
- rst asserted in WAIT, then mem_rvalid → all outputs 0 immediately, no rd_valid afterwards; a new request after reset completes normally.
